reg_write_sched: RTL and testbench
==================================

# reg_write_sched

Write-port scheduler and scoreboard for the clocked register file. Shares the file's single write port between the in-order writeback stage and the out-of-order load/long-latency return path. Buffers losing load returns in a small FIFO and tracks registers with outstanding loads. Drives a read-hazard stall to decode so operands are never read before their load result is written.

## Interface

Parameters:
- ADDR_WIDTH, 4, register address width (16 architectural registers)
- WORD, 32, data width
- FIFO_DEPTH, 2, load-return buffer entries (power of two, ≥2)

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- rst_n_i  in  1  reset, synchronous and active-low
- wb_valid_i  in  1  writeback stage has a result this cycle (never stalled)
- wb_addr_i  in  ADDR_WIDTH  writeback destination
- wb_data_i  in  WORD  writeback data
- ld_valid_i  in  1  load return valid
- ld_addr_i  in  ADDR_WIDTH  load destination
- ld_data_i  in  WORD  load data
- ld_ready_o  out  1  scheduler can accept a load return
- issue_valid_i  in  1  a load/long-latency op is issued this cycle
- issue_addr_i  in  ADDR_WIDTH  its destination register
- rd_en_i  in  3  per-port read enables from decode
- rd_addr_1_i, rd_addr_2_i, rd_addr_3_i  in  ADDR_WIDTH each  decode read addresses
- hazard_o  out  1  decode must stall
- write_en_o  out  1  to register file write_en
- write_addr_o  out  ADDR_WIDTH  to register file write address
- write_data_o  out  WORD  to register file write data
- pending_o  out  2**ADDR_WIDTH  scoreboard bits
- waw_err_o  out  1  sticky: writeback hit a pending register

## Operation

- Load handshake: fire = ld_valid_i && ld_ready_o. ld_ready_o = (count < FIFO_DEPTH) and 0 while rst_n_i low. Loads with ld_valid_i high and ld_ready_o low are not taken; requester holds values.
- Per-cycle source select, priority order, result registered into write_*_o:
  - wb_valid_i: write wb_addr_i/wb_data_i.
  - else FIFO non-empty: write FIFO head, pop.
  - else fire: write ld_* directly (bypass, not pushed).
  - else write_en_o <= 0; write_addr_o/write_data_o hold previous values.
- Push: fire and not bypassed → ld_* pushed at tail. Push and pop in same cycle allowed; count unchanged. Pointers wrap modulo FIFO_DEPTH. Strict FIFO order among loads.
- Scoreboard: pending[issue_addr_i] set on issue_valid_i. pending[r] cleared on the edge where a load-sourced write (FIFO or bypass) to r is registered. Simultaneous set and clear of same r: set wins. Writeback never clears pending.
- hazard_o (combinational) = OR over k of rd_en_i[k] && pending[rd_addr_k_i]. Also asserted if issue_valid_i && pending[issue_addr_i] (WAW on issue).
- waw_err_o set on edge where wb_valid_i && pending[wb_addr_i]. The wb write still proceeds. Cleared only by reset.
- Register 15 receives no special handling.

## Timing

- Reset (edge with rst_n_i low): write_en_o=0, write_addr_o=0, write_data_o=0, pending_o=0, waw_err_o=0, FIFO empty (count=0, pointers 0). hazard_o follows its equation (0 once pending_o clears). Reset mid-operation discards buffered loads and scoreboard.
- Latency: write input to write_en_o is 1 cycle (bypass or wb). Buffered load writes N+1 cycles after acceptance, where N = cycles in which wb_valid_i or older entries won.
- pending clears on the same edge write_en_o rises for that load. A read of that register in the following cycle sees no hazard. The register file's forwarding supplies the data.
- Sustained wb_valid_i starves loads. FIFO fills after FIFO_DEPTH accepted loads; ld_ready_o low the cycle after count reaches FIFO_DEPTH. It returns high the cycle after the first pop.
- No combinational path from ld_valid_i to ld_ready_o.

## Test plan

- Reset then idle: after edge with rst_n_i=0, write_en_o=0, pending_o=0, ld_ready_o=1 once released; hazard_o=0 with rd_en_i=3'b111.
- Bypass: issue r3, then ld r3=0xDEADBEEF with wb idle → next cycle write_en_o=1, addr 3, data 0xDEADBEEF; pending[3] clears the same edge. A read of r3 asserts hazard_o until then.
- Conflict buffering: wb r1=0x11 for 4 cycles while loads r4=0xA, r5=0xB offered. Both accepted; ld_ready_o=0 after second. After wb stops: r4 then r5 written on consecutive cycles.
- Simultaneous push/pop: FIFO holds r4, wb idle, new load r6 offered → r4 written, r6 enqueued, count stays 1, r6 written next cycle.
- Set-wins and WAW: issue r7 on the edge r7's load is written → pending[7] stays 1. Then wb to r7 → waw_err_o=1 and stays until reset.
- Reset mid-operation: FIFO full and pending_o=0x0030, reset asserted one cycle → FIFO empty, pending_o=0, no further writes of the flushed loads.

Source files
------------

// File: rtl/reg_write_sched.sv
// rtl/reg_write_sched.sv - shares the register file write port between writeback and load returns
// Load returns that lose to writeback are buffered; a scoreboard stalls decode on pending loads.
module reg_write_sched #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]    wb_addr_i,
  input  logic [WORD-1:0]          wb_data_i,
  input  logic                     ld_valid_i,
  input  logic [ADDR_WIDTH-1:0]    ld_addr_i,
  input  logic [WORD-1:0]          ld_data_i,
  output logic                     ld_ready_o,
  input  logic                     issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]    issue_addr_i,
  input  logic [2:0]               rd_en_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_1_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_2_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_3_i,
  output logic                     hazard_o,
  output logic                     write_en_o,
  output logic [ADDR_WIDTH-1:0]    write_addr_o,
  output logic [WORD-1:0]          write_data_o,
  output logic [2**ADDR_WIDTH-1:0] pending_o,
  output logic                     waw_err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REGS  = 2**ADDR_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [WORD-1:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;

  logic                  fire;
  logic                  fifo_empty;
  logic                  sel_fifo;
  logic                  sel_byp;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [REGS-1:0]       pending_next;

  // Ready depends only on registered count and reset, never on ld_valid_i.
  assign ld_ready_o = rst_n_i && (count < DEPTH_C);
  assign fire       = ld_valid_i && ld_ready_o;
  assign fifo_empty = (count == '0);

  always_comb begin
    sel_fifo     = !wb_valid_i && !fifo_empty;
    sel_byp      = !wb_valid_i && fifo_empty && fire;
    pop          = sel_fifo;
    push         = fire && !sel_byp;
    clr_addr     = sel_fifo ? fifo_addr[rd_ptr] : ld_addr_i;
    pending_next = pending_o;
    // Clear first so a same-cycle issue to the same register wins.
    if (sel_fifo || sel_byp) pending_next[clr_addr] = 1'b0;
    if (issue_valid_i)       pending_next[issue_addr_i] = 1'b1;
  end

  always_comb begin
    hazard_o = (rd_en_i[0] && pending_o[rd_addr_1_i]) ||
               (rd_en_i[1] && pending_o[rd_addr_2_i]) ||
               (rd_en_i[2] && pending_o[rd_addr_3_i]) ||
               (issue_valid_i && pending_o[issue_addr_i]);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr_i;
      fifo_data[wr_ptr] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      pending_o    <= '0;
      waw_err_o    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      write_en_o <= wb_valid_i || sel_fifo || sel_byp;
      if (wb_valid_i) begin
        write_addr_o <= wb_addr_i;
        write_data_o <= wb_data_i;
      end else if (sel_fifo) begin
        write_addr_o <= fifo_addr[rd_ptr];
        write_data_o <= fifo_data[rd_ptr];
      end else if (sel_byp) begin
        write_addr_o <= ld_addr_i;
        write_data_o <= ld_data_i;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      pending_o <= pending_next;
      if (wb_valid_i && pending_o[wb_addr_i]) waw_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_sched.sv
// tb/tb_reg_write_sched.sv - randomized and directed bench for reg_write_sched against a queue model
module tb_reg_write_sched;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_addr = '0;
  logic [2:0]  rd_en = '0;
  logic [3:0]  rd_addr_1 = '0;
  logic [3:0]  rd_addr_2 = '0;
  logic [3:0]  rd_addr_3 = '0;
  logic        hazard;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [15:0] pending;
  logic        waw_err;

  int checks = 0;
  int errors = 0;

  reg_write_sched #(.ADDR_WIDTH(4), .WORD(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
    .rd_en_i(rd_en), .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2), .rd_addr_3_i(rd_addr_3),
    .hazard_o(hazard), .write_en_o(write_en), .write_addr_o(write_addr),
    .write_data_o(write_data), .pending_o(pending), .waw_err_o(waw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_pend = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic        m_waw = 1'b0;
  logic        m_fired = 1'b0;
  logic        m_init = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of accepted loads plus a pending bit vector.
  always @(posedge clk) begin
    ent_t e;
    logic f, byp, clr;
    logic [3:0] ca;
    if (!rst_n) begin
      m_q.delete();
      m_pend = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_waw = 1'b0;
      m_fired = 1'b0; m_init = 1'b1;
    end else begin
      f = ld_valid && (m_q.size() < DEPTH);
      byp = 1'b0; clr = 1'b0; ca = '0;
      if (wb_valid) begin
        m_we = 1'b1; m_wa = wb_addr; m_wd = wb_data;
        if (m_pend[wb_addr]) m_waw = 1'b1;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d; clr = 1'b1; ca = e.a;
      end else if (f) begin
        m_we = 1'b1; m_wa = ld_addr; m_wd = ld_data; byp = 1'b1; clr = 1'b1; ca = ld_addr;
      end else begin
        m_we = 1'b0;
      end
      if (f && !byp) m_q.push_back('{a: ld_addr, d: ld_data});
      if (clr) m_pend[ca] = 1'b0;
      if (issue_valid) m_pend[issue_addr] = 1'b1;
      m_fired = f;
    end
  end

  always @(negedge clk) begin
    logic exp_haz;
    if (m_init) begin
      exp_haz = (rd_en[0] && m_pend[rd_addr_1]) || (rd_en[1] && m_pend[rd_addr_2]) ||
                (rd_en[2] && m_pend[rd_addr_3]) || (issue_valid && m_pend[issue_addr]);
      check("write_en", 32'(write_en), 32'(m_we));
      if (m_we) begin
        check("write_addr", 32'(write_addr), 32'(m_wa));
        check("write_data", write_data, m_wd);
      end
      check("pending", 32'(pending), 32'(m_pend));
      check("waw_err", 32'(waw_err), 32'(m_waw));
      check("ld_ready", 32'(ld_ready), 32'(rst_n && (m_q.size() < DEPTH)));
      check("hazard", 32'(hazard), 32'(exp_haz));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0; rd_en = 3'b111;
    tick; tick;
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    rst_n = 1'b1; #1;
    check("idle_ld_ready", 32'(ld_ready), 32'd1);
    check("idle_hazard", 32'(hazard), 32'd0);
    rd_en = 3'b000;

    // Bypass
    issue_valid = 1'b1; issue_addr = 4'd3; tick;
    issue_valid = 1'b0;
    rd_en = 3'b001; rd_addr_1 = 4'd3;
    ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 32'hDEADBEEF; #1;
    check("byp_hazard_before", 32'(hazard), 32'd1);
    tick;
    ld_valid = 1'b0;
    check("byp_we", 32'(write_en), 32'd1);
    check("byp_addr", 32'(write_addr), 32'd3);
    check("byp_data", write_data, 32'hDEADBEEF);
    check("byp_pend3", 32'(pending[3]), 32'd0);
    check("byp_hazard_after", 32'(hazard), 32'd0);
    rd_en = 3'b000;

    // Conflict buffering
    issue_valid = 1'b1; issue_addr = 4'd4; tick;
    issue_addr = 4'd5; tick;
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 32'h11;
    ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'hA; tick;
    check("cf_ready_after1", 32'(ld_ready), 32'd1);
    ld_addr = 4'd5; ld_data = 32'hB; tick;
    check("cf_ready_full", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0; tick; tick;
    check("cf_wb_data", write_data, 32'h11);
    wb_valid = 1'b0; tick;
    check("cf_first_addr", 32'(write_addr), 32'd4);
    check("cf_first_data", write_data, 32'hA);
    check("cf_pend4", 32'(pending[4]), 32'd0);
    check("cf_ready_back", 32'(ld_ready), 32'd1);
    tick;
    check("cf_second_addr", 32'(write_addr), 32'd5);
    check("cf_second_data", write_data, 32'hB);
    tick;
    check("cf_idle_we", 32'(write_en), 32'd0);

    // Simultaneous push/pop
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h22;
    ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'hC; tick;
    wb_valid = 1'b0; ld_addr = 4'd6; ld_data = 32'hD; tick;
    ld_valid = 1'b0;
    check("pp_addr", 32'(write_addr), 32'd4);
    check("pp_ready", 32'(ld_ready), 32'd1);
    tick;
    check("pp_next_addr", 32'(write_addr), 32'd6);
    check("pp_next_data", write_data, 32'hD);

    // Set-wins and WAW
    issue_valid = 1'b1; issue_addr = 4'd7; tick;
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 32'hE; #1;
    check("sw_issue_hazard", 32'(hazard), 32'd1);
    tick;
    issue_valid = 1'b0; ld_valid = 1'b0;
    check("sw_addr", 32'(write_addr), 32'd7);
    check("sw_pend7", 32'(pending[7]), 32'd1);
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h77; tick;
    wb_valid = 1'b0;
    check("waw_set", 32'(waw_err), 32'd1);
    check("waw_write", write_data, 32'h77);
    tick; tick;
    check("waw_sticky", 32'(waw_err), 32'd1);

    // Reset mid-operation
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 32'h7; tick;
    ld_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 4'd4; tick;
    issue_addr = 4'd5;
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 32'h1;
    ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'h44; tick;
    issue_valid = 1'b0; ld_addr = 4'd5; ld_data = 32'h55; tick;
    ld_valid = 1'b0;
    check("rm_full", 32'(ld_ready), 32'd0);
    check("rm_pend", 32'(pending), 32'h0030);
    wb_valid = 1'b0; rst_n = 1'b0; tick;
    check("rm_pend_clr", 32'(pending), 32'd0);
    check("rm_we", 32'(write_en), 32'd0);
    check("rm_waw_clr", 32'(waw_err), 32'd0);
    rst_n = 1'b1; #1;
    check("rm_ready", 32'(ld_ready), 32'd1);
    tick; tick;
    check("rm_no_flushed_write", 32'(write_en), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_addr = 4'($urandom_range(0, 15));
      wb_data = $urandom;
      if (!(ld_valid && !m_fired)) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_addr = 4'($urandom_range(0, 7));
        ld_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr = 4'($urandom_range(0, 7));
      rd_en = 3'($urandom_range(0, 7));
      rd_addr_1 = 4'($urandom_range(0, 15));
      rd_addr_2 = 4'($urandom_range(0, 15));
      rd_addr_3 = 4'($urandom_range(0, 15));
      tick;
    end

    rst_n = 1'b1; wb_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0; rd_en = '0;
    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
